// File: rtl/button_debouncer.sv
// Push-button debouncer: four-state qualify FSM with abort counter.
// Optional two-flop input synchronizer enabled by DEBOUNCE_SYNC_EN.
module button_debouncer #(
    parameter logic [15:0] CNT_MAX = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pb_in,
    output logic       pb_out,
    output logic       busy,
    output logic [7:0] bounce_cnt
);

    // bit1 = debounced level, bit0 ^ bit1 = qualifying
    typedef enum logic [1:0] {
        LOW      = 2'b00,
        CHK_HIGH = 2'b01,
        HIGH     = 2'b11,
        CHK_LOW  = 2'b10
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [7:0]  bnc_n;
    logic        s;
    logic        at_max;
    logic        bnc_sat;

`ifdef DEBOUNCE_SYNC_EN
    logic sync1, sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pb_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = pb_in;
`endif

    assign at_max  = (cnt == CNT_MAX - 16'd1);
    assign bnc_sat = &bounce_cnt;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bnc_n   = bounce_cnt;
        unique case (state)
            LOW: begin
                if (s) begin
                    state_n = CHK_HIGH;
                    cnt_n   = '0;
                end
            end
            CHK_HIGH: begin
                if (!s) begin
                    state_n = LOW;
                    cnt_n   = '0;
                    if (!bnc_sat)
                        bnc_n = bounce_cnt + 8'd1;
                end else if (at_max) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_n = CHK_LOW;
                    cnt_n   = '0;
                end
            end
            CHK_LOW: begin
                if (s) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                    if (!bnc_sat)
                        bnc_n = bounce_cnt + 8'd1;
                end else if (at_max) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOW;
            cnt        <= '0;
            bounce_cnt <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bounce_cnt <= bnc_n;
        end
    end

    assign pb_out = state[1];
    assign busy   = state[1] ^ state[0];

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with a run-length reference model.
// Honours DEBOUNCE_SYNC_EN by delaying the model's view of pb_in by 2.
module tb_button_debouncer;

    localparam int CNT_MAX = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       pb_in;
    logic       pb_out;
    logic       busy;
    logic [7:0] bounce_cnt;

    int checks = 0;
    int errors = 0;

    button_debouncer #(
        .CNT_MAX(16'(CNT_MAX))
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pb_in     (pb_in),
        .pb_out    (pb_out),
        .busy      (busy),
        .bounce_cnt(bounce_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: level flips once CNT_MAX+1 consecutive samples disagree
    int   m_out = 0;
    int   m_run = 0;
    int   m_bnc = 0;
    logic [1:0] hist = '0;
    bit   armed = 0;

    always @(posedge clk) begin
        bit sv;
        armed = 1;
        if (reset) begin
            m_out = 0;
            m_run = 0;
            m_bnc = 0;
            hist  = '0;
        end else begin
            sv   = (LAT == 2) ? hist[1] : pb_in;
            hist = {hist[0], pb_in};
            if (int'(sv) != m_out) begin
                m_run++;
                if (m_run == CNT_MAX + 1) begin
                    m_out = int'(sv);
                    m_run = 0;
                end
            end else begin
                if (m_run > 0 && m_bnc < 255)
                    m_bnc++;
                m_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model_pb_out", int'(pb_out), m_out);
            chk("model_busy", int'(busy), int'(m_run > 0));
            chk("model_bounce", int'(bounce_cnt), m_bnc);
        end
    end

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic expect_out(input string nm, input int p,
                              input int b, input int c);
        chk({nm, "_pb_out"}, int'(pb_out), p);
        chk({nm, "_busy"}, int'(busy), b);
        chk({nm, "_bounce"}, int'(bounce_cnt), c);
    endtask

    initial begin
        reset = 1'b1;
        pb_in = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            edges(1);
            expect_out("reset", 0, 0, 0);
        end
        reset = 1'b0;

        edges(1 + LAT);
        expect_out("rise_start", 0, 1, 0);
        edges(3);
        expect_out("rise_pre", 0, 1, 0);
        edges(1);
        expect_out("rise_done", 1, 0, 0);

        pb_in = 1'b0;
        edges(5 + LAT);
        expect_out("fall_done", 0, 0, 0);

        pb_in = 1'b1;
        edges(4);
        expect_out("pulse4_mid", 0, 1, 0);
        pb_in = 1'b0;
        edges(1 + LAT);
        expect_out("pulse4_end", 0, 0, 1);

        for (int i = 0; i < 2; i++) begin
            pb_in = 1'b1;
            edges(1);
            pb_in = 1'b0;
            edges(1);
        end
        edges(LAT);
        expect_out("toggle", 0, 0, 3);

        pb_in = 1'b1;
        edges(5 + LAT);
        expect_out("high", 1, 0, 3);

        pb_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edges(1);
            chk("dip_hold", int'(pb_out), 1);
        end
        pb_in = 1'b1;
        for (int i = 0; i < 1 + LAT; i++) begin
            edges(1);
            chk("dip_hold", int'(pb_out), 1);
        end
        expect_out("dip_end", 1, 0, 4);

        for (int i = 0; i < 300; i++) begin
            pb_in = 1'b0;
            edges(1);
            pb_in = 1'b1;
            edges(1);
        end
        edges(LAT);
        expect_out("saturate", 1, 0, 255);
        for (int i = 0; i < 5; i++) begin
            pb_in = 1'b0;
            edges(1);
            pb_in = 1'b1;
            edges(1);
        end
        edges(LAT);
        expect_out("sat_hold", 1, 0, 255);

        pb_in = 1'b0;
        edges(5 + LAT);
        expect_out("low_again", 0, 0, 255);
        pb_in = 1'b1;
        edges(2 + LAT);
        expect_out("mid_check", 0, 1, 255);
        reset = 1'b1;
        edges(1);
        expect_out("mid_reset", 0, 0, 0);
        reset = 1'b0;
        pb_in = 1'b0;
        edges(3);
        expect_out("post_reset", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
